// File: rtl/rv_pkg.sv
// Shared constants for the integer register file and its read ports.
package rv_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned NREGS    = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/regfile_sb_rdport.sv
// One combinational read port: range check, register-0 forcing and write-port bypass.
module regfile_sb_rdport
  import rv_pkg::REG_ZERO;
#(
  parameter int unsigned XLEN   = rv_pkg::XLEN,
  parameter int unsigned NREGS  = rv_pkg::NREGS,
  parameter int unsigned ADDR_W = rv_pkg::ADDR_W,
  parameter int unsigned BYPASS = 1
) (
  input  logic [ADDR_W-1:0] rd_num_i,
  input  logic [XLEN-1:0]   regs_i [NREGS],
  input  logic [NREGS-1:0]  busy_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wr_num_i,
  input  logic [XLEN-1:0]   wr_value_i,
  output logic [XLEN-1:0]   rd_value_o,
  output logic              rd_busy_o
);

  logic            valid;
  logic            hit;
  logic [XLEN-1:0] stored;
  logic            stored_busy;

  always_comb begin
    stored      = '0;
    stored_busy = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      if (rd_num_i == ADDR_W'(r)) begin
        stored      = regs_i[r];
        stored_busy = busy_i[r];
      end
    end

    valid = (rd_num_i != ADDR_W'(REG_ZERO)) && (32'(rd_num_i) < NREGS);
    hit   = (BYPASS != 0) && we_i && (wr_num_i == rd_num_i) && valid;

    if (!valid) begin
      rd_value_o = '0;
      rd_busy_o  = 1'b0;
    end else if (hit) begin
      // The write in flight retires the pending op, so the forwarded value is never busy.
      rd_value_o = wr_value_i;
      rd_busy_o  = 1'b0;
    end else begin
      rd_value_o = stored;
      rd_busy_o  = stored_busy;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with synchronous reset, write bypass and a per-register busy
// scoreboard used by decode to stall on loads and other long-latency producers.
module regfile_sb
  import rv_pkg::REG_ZERO;
#(
  parameter int unsigned XLEN   = rv_pkg::XLEN,
  parameter int unsigned NREGS  = rv_pkg::NREGS,
  parameter int unsigned ADDR_W = rv_pkg::ADDR_W,
  parameter int unsigned NRD    = 2,
  parameter int unsigned BYPASS = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NRD*ADDR_W-1:0] rd_num_i,
  output logic [NRD*XLEN-1:0]   rd_value_o,
  output logic [NRD-1:0]        rd_busy_o,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     wr_num_i,
  input  logic [XLEN-1:0]       wr_value_i,
  input  logic                  issue_i,
  input  logic [ADDR_W-1:0]     issue_num_i,
  output logic [ADDR_W:0]       busy_cnt_o,
  output logic                  any_busy_o
);

  localparam int unsigned CntW = ADDR_W + 1;

  function automatic logic [CntW-1:0] popcount(input logic [NREGS-1:0] vec);
    logic [CntW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt = cnt + CntW'(vec[i]);
    end
    return cnt;
  endfunction

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [CntW-1:0]  busy_cnt_q, busy_cnt_d;
  logic             any_busy_q, any_busy_d;
  logic             wr_ok, iss_ok;

  assign wr_ok  = we_i && (wr_num_i != ADDR_W'(REG_ZERO)) && (32'(wr_num_i) < NREGS);
  assign iss_ok = issue_i && (issue_num_i != ADDR_W'(REG_ZERO)) && (32'(issue_num_i) < NREGS);

  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NREGS; r++) begin
      if (wr_ok && (wr_num_i == ADDR_W'(r))) busy_d[r] = 1'b0;
      // Issue is applied last: a new pending op outranks the write that lands this cycle.
      if (iss_ok && (issue_num_i == ADDR_W'(r))) busy_d[r] = 1'b1;
    end
    busy_cnt_d = popcount(busy_d);
    any_busy_d = (busy_cnt_d != '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
      any_busy_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (wr_ok && (wr_num_i == ADDR_W'(r))) regs_q[r] <= wr_value_i;
      end
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
      any_busy_q <= any_busy_d;
    end
  end

  assign busy_cnt_o = busy_cnt_q;
  assign any_busy_o = any_busy_q;

  for (genvar p = 0; p < NRD; p++) begin : g_rdport
    regfile_sb_rdport #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .ADDR_W(ADDR_W),
      .BYPASS(BYPASS)
    ) u_rdport (
      .rd_num_i  (rd_num_i[p*ADDR_W +: ADDR_W]),
      .regs_i    (regs_q),
      .busy_i    (busy_q),
      .we_i      (we_i),
      .wr_num_i  (wr_num_i),
      .wr_value_i(wr_value_i),
      .rd_value_o(rd_value_o[p*XLEN +: XLEN]),
      .rd_busy_o (rd_busy_o[p])
    );
  end

endmodule
